morse_tx_encoder: RTL and testbench

Morse keying transmitter: accepts 6-bit symbol codes over a valid/ready handshake and drives a single on/off key line with standard Morse timing (dot = 1 unit, dash = 3, element gap = 1, character gap = 3, word gap = 7). It is the send-side counterpart of the Morse decode/display path and uses the same 6-bit symbol space. All timing derives from one clock through a programmable unit counter.

---
 rtl/morse_tx_encoder_if.sv | 9 +
 rtl/morse_tx_encoder.sv | 226 ++++++++++++++++++++++
 tb/tb_morse_tx_encoder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/morse_tx_encoder_if.sv
// Symbol handshake between the upstream symbol source and the Morse keying transmitter.
interface morse_tx_encoder_if;
    logic [5:0] sym_code;
    logic       sym_valid;
    logic       sym_ready;

    modport master (output sym_code, output sym_valid, input sym_ready);
    modport slave  (input sym_code, input sym_valid, output sym_ready);
endinterface

// File: rtl/morse_tx_encoder.sv
// Morse keying transmitter: 6-bit symbol codes in, ITU-timed key line out.
// Optional sidetone generator enabled by defining MORSE_TX_SIDETONE_EN.
module morse_tx_encoder #(
    parameter int unsigned UNIT_CYCLES      = 1000,
    parameter int unsigned TONE_HALF_CYCLES = 50
) (
    input  logic                      clk,
    input  logic                      rst_n,
    morse_tx_encoder_if.slave         sym_if,
    output logic                      key_out,
    output logic                      busy,
    output logic                      err,
    output logic                      tone_out
);

    localparam int unsigned CNT_W = $clog2(7 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] LD_1U = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_3U = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_7U = CNT_W'(7 * UNIT_CYCLES - 1);

    if (UNIT_CYCLES < 1 || TONE_HALF_CYCLES < 1) begin : g_param_check
        $error("morse_tx_encoder: UNIT_CYCLES and TONE_HALF_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_ESPACE,
        S_CGAP,
        S_WGAP
    } state_e;

    // Pattern ROM: {len, pat} with pat left-aligned so the next element is always bit 4 (1 = dash).
    function automatic logic [7:0] sym_rom(input logic [5:0] code);
        logic [7:0] r;
        case (code)
            6'd1:    r = {3'd2, 5'b01000}; // A
            6'd2:    r = {3'd4, 5'b10000}; // B
            6'd3:    r = {3'd4, 5'b10100}; // C
            6'd4:    r = {3'd3, 5'b10000}; // D
            6'd5:    r = {3'd1, 5'b00000}; // E
            6'd6:    r = {3'd4, 5'b00100}; // F
            6'd7:    r = {3'd3, 5'b11000}; // G
            6'd8:    r = {3'd4, 5'b00000}; // H
            6'd9:    r = {3'd2, 5'b00000}; // I
            6'd10:   r = {3'd4, 5'b01110}; // J
            6'd11:   r = {3'd3, 5'b10100}; // K
            6'd12:   r = {3'd4, 5'b01000}; // L
            6'd13:   r = {3'd2, 5'b11000}; // M
            6'd14:   r = {3'd2, 5'b10000}; // N
            6'd15:   r = {3'd3, 5'b11100}; // O
            6'd16:   r = {3'd4, 5'b01100}; // P
            6'd17:   r = {3'd4, 5'b11010}; // Q
            6'd18:   r = {3'd3, 5'b01000}; // R
            6'd19:   r = {3'd3, 5'b00000}; // S
            6'd20:   r = {3'd1, 5'b10000}; // T
            6'd21:   r = {3'd3, 5'b00100}; // U
            6'd22:   r = {3'd4, 5'b00010}; // V
            6'd23:   r = {3'd3, 5'b01100}; // W
            6'd24:   r = {3'd4, 5'b10010}; // X
            6'd25:   r = {3'd4, 5'b10110}; // Y
            6'd26:   r = {3'd4, 5'b11000}; // Z
            6'd27:   r = {3'd5, 5'b11111}; // 0
            6'd28:   r = {3'd5, 5'b01111}; // 1
            6'd29:   r = {3'd5, 5'b00111}; // 2
            6'd30:   r = {3'd5, 5'b00011}; // 3
            6'd31:   r = {3'd5, 5'b00001}; // 4
            6'd32:   r = {3'd5, 5'b00000}; // 5
            6'd33:   r = {3'd5, 5'b10000}; // 6
            6'd34:   r = {3'd5, 5'b11000}; // 7
            6'd35:   r = {3'd5, 5'b11100}; // 8
            6'd36:   r = {3'd5, 5'b11110}; // 9
            default: r = 8'h00;            // word space / invalid: len 0
        endcase
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       pat_q, pat_d;
    logic [2:0]       rem_q, rem_d;
    logic             key_q, key_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;

    logic [7:0]       rom_w;
    logic [2:0]       rom_len;
    logic [4:0]       rom_pat;
    logic             accept;

    assign rom_w   = sym_rom(sym_if.sym_code);
    assign rom_len = rom_w[7:5];
    assign rom_pat = rom_w[4:0];
    assign accept  = sym_if.sym_valid && ready_q;

    // Next-state, element sequencing and interval counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        rem_d   = rem_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (sym_if.sym_code == 6'd0) begin
                        state_d = S_WGAP;
                        cnt_d   = LD_7U;
                    end else if (rom_len != 3'd0) begin
                        state_d = S_MARK;
                        pat_d   = rom_pat;
                        rem_d   = rom_len;
                        cnt_d   = rom_pat[4] ? LD_3U : LD_1U;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            S_MARK: begin
                if (cnt_q == '0) begin
                    if (rem_q > 3'd1) begin
                        state_d = S_ESPACE;
                        cnt_d   = LD_1U;
                        pat_d   = {pat_q[3:0], 1'b0};
                        rem_d   = rem_q - 3'd1;
                    end else begin
                        state_d = S_CGAP;
                        cnt_d   = LD_3U;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ESPACE: begin
                if (cnt_q == '0) begin
                    state_d = S_MARK;
                    cnt_d   = pat_q[4] ? LD_3U : LD_1U;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CGAP, S_WGAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        key_d   = (state_d == S_MARK);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            rem_q   <= '0;
            key_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            rem_q   <= rem_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign sym_if.sym_ready = ready_q;
    assign key_out          = key_q;
    assign busy             = busy_q;
    assign err              = err_q;

`ifdef MORSE_TX_SIDETONE_EN
    localparam int unsigned TD_W = (TONE_HALF_CYCLES > 1) ? $clog2(TONE_HALF_CYCLES) : 1;

    logic [TD_W-1:0] tdiv_q, tdiv_d;
    logic            tone_q, tone_d;

    // Tone starts high with the carrier, toggles every TONE_HALF_CYCLES, forced low between marks.
    always_comb begin
        tdiv_d = '0;
        tone_d = 1'b0;
        if (key_d) begin
            if (!key_q) begin
                tone_d = 1'b1;
            end else if (tdiv_q == TD_W'(TONE_HALF_CYCLES - 1)) begin
                tone_d = ~tone_q;
            end else begin
                tone_d = tone_q;
                tdiv_d = tdiv_q + TD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tdiv_q <= '0;
            tone_q <= 1'b0;
        end else begin
            tdiv_q <= tdiv_d;
            tone_q <= tone_d;
        end
    end

    assign tone_out = tone_q;
`else
    assign tone_out = 1'b0;
`endif

endmodule

// File: tb/tb_morse_tx_encoder.sv
// Directed bench for morse_tx_encoder: UNIT_CYCLES=4 main instance plus a UNIT_CYCLES=1 instance.
module tb_morse_tx_encoder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    morse_tx_encoder_if bus0 ();
    morse_tx_encoder_if bus1 ();

    logic key0, busy0, err0, tone0;
    logic key1, busy1, err1, tone1;

    morse_tx_encoder #(.UNIT_CYCLES(4), .TONE_HALF_CYCLES(2)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .sym_if   (bus0.slave),
        .key_out  (key0),
        .busy     (busy0),
        .err      (err0),
        .tone_out (tone0)
    );

    morse_tx_encoder #(.UNIT_CYCLES(1), .TONE_HALF_CYCLES(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .sym_if   (bus1.slave),
        .key_out  (key1),
        .busy     (busy1),
        .err      (err1),
        .tone_out (tone1)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? bus1.sym_ready : bus0.sym_ready;
    endfunction

    task automatic drive(input bit sel, input logic [5:0] code, input logic v);
        if (sel) begin
            bus1.sym_code  = code;
            bus1.sym_valid = v;
        end else begin
            bus0.sym_code  = code;
            bus0.sym_valid = v;
        end
    endtask

    // Leaves the bench at a falling edge with sym_ready high (or reports a timeout).
    task automatic wait_ready(input bit sel);
        int t = 0;
        @(negedge clk);
        while (rdy(sel) !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("wait_ready_timeout", 64'(rdy(sel)), 64'd1);
    endtask

    // Sends one symbol and records key/busy/ready/err/tone for n cycles after acceptance (bit 0 = cycle 1).
    task automatic send_cap(input bit sel, input logic [5:0] code, input int n,
                            output logic [63:0] kv, output logic [63:0] bv,
                            output logic [63:0] rv, output logic [63:0] ev,
                            output logic [63:0] tv);
        kv = '0; bv = '0; rv = '0; ev = '0; tv = '0;
        wait_ready(sel);
        drive(sel, code, 1'b1);
        @(posedge clk);
        #1 drive(sel, code, 1'b0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            kv[i] = sel ? key1  : key0;
            bv[i] = sel ? busy1 : busy0;
            rv[i] = rdy(sel);
            ev[i] = sel ? err1  : err0;
            tv[i] = sel ? tone1 : tone0;
        end
    endtask

    task automatic sym_test(input string tag, input bit sel, input logic [5:0] code, input int n,
                            input logic [63:0] ek, input logic [63:0] eb,
                            input logic [63:0] er, input logic [63:0] ee);
        logic [63:0] kv, bv, rv, ev, tv;
        send_cap(sel, code, n, kv, bv, rv, ev, tv);
        chk({tag, "_key"},   kv, ek);
        chk({tag, "_busy"},  bv, eb);
        chk({tag, "_ready"}, rv, er);
        chk({tag, "_err"},   ev, ee);
`ifndef MORSE_TX_SIDETONE_EN
        chk({tag, "_tone"},  tv, 64'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          last_hi, idle_at, next_hi;
        logic [63:0] kv2;

        rst_n = 1'b0;
        drive(1'b0, 6'd0, 1'b0);
        drive(1'b1, 6'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 64'(bus0.sym_ready), 64'd1);
        chk("rst_key0",   64'(key0),  64'd0);
        chk("rst_busy0",  64'(busy0), 64'd0);
        chk("rst_err0",   64'(err0),  64'd0);
        chk("rst_tone0",  64'(tone0), 64'd0);
        chk("rst_ready1", 64'(bus1.sym_ready), 64'd1);
        rst_n = 1'b1;

        // UNIT_CYCLES = 4
        sym_test("E",     1'b0, 6'd5,  17, 64'hF,       64'hFFFF,      64'h1_0000,      64'h0);
        sym_test("A",     1'b0, 6'd1,  33, 64'hF_FF0F,  64'hFFFF_FFFF, 64'h1_0000_0000, 64'h0);
        sym_test("WSP",   1'b0, 6'd0,  29, 64'h0,       64'h0FFF_FFFF, 64'h1000_0000,   64'h0);
        sym_test("INV50", 1'b0, 6'd50,  3, 64'h0,       64'h0,         64'h7,           64'h1);

        // '0' then '4' with sym_valid held: CGAP of 12 busy cycles, then one IDLE handoff cycle.
        wait_ready(1'b0);
        drive(1'b0, 6'd27, 1'b1);
        @(posedge clk);
        #1 bus0.sym_code = 6'd31;
        last_hi = 0; idle_at = 0; next_hi = 0; kv2 = '0;
        for (int i = 1; i <= 145; i++) begin
            @(negedge clk);
            if (idle_at == 0 && bus0.sym_ready === 1'b1) idle_at = i;
            if (idle_at == 0 && key0 === 1'b1) last_hi = i;
            if (idle_at != 0 && next_hi == 0 && key0 === 1'b1) next_hi = i;
            if (i >= 90) kv2[i-90] = key0;
            if (i == 145) bus0.sym_valid = 1'b0;
        end
        chk("b2b_last_dash",  64'(last_hi), 64'd76);
        chk("b2b_ready",      64'(idle_at), 64'd89);
        chk("b2b_gap_low",    64'(idle_at - last_hi - 1), 64'd12);
        chk("b2b_first_dot",  64'(next_hi), 64'd90);
        chk("b2b_key_4",      kv2, 64'h0000_0FFF_0F0F_0F0F);

        // Reset during the dash of 'A'.
        wait_ready(1'b0);
        drive(1'b0, 6'd1, 1'b1);
        @(posedge clk);
        #1 drive(1'b0, 6'd1, 1'b0);
        repeat (12) @(negedge clk);
        chk("rstmid_key_before", 64'(key0), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_key",   64'(key0),  64'd0);
        chk("rstmid_ready", 64'(bus0.sym_ready), 64'd1);
        chk("rstmid_busy",  64'(busy0), 64'd0);
        chk("rstmid_err",   64'(err0),  64'd0);
        rst_n = 1'b1;
        sym_test("E_post_rst", 1'b0, 6'd5, 17, 64'hF, 64'hFFFF, 64'h1_0000, 64'h0);

        // UNIT_CYCLES = 1
        sym_test("U1_E",     1'b1, 6'd5,  5,  64'h1,      64'hF,       64'h10,       64'h0);
        sym_test("U1_9",     1'b1, 6'd36, 21, 64'h1_7777, 64'hF_FFFF,  64'h10_0000,  64'h0);
        sym_test("U1_Q",     1'b1, 6'd17, 17, 64'h1D77,   64'hFFFF,    64'h1_0000,   64'h0);
        sym_test("U1_Z",     1'b1, 6'd26, 15, 64'h577,    64'h3FFF,    64'h4000,     64'h0);
        sym_test("U1_INV63", 1'b1, 6'd63,  2, 64'h0,      64'h0,       64'h3,        64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
